// File: rtl/axis_write_arb.sv
// rtl/axis_write_arb.sv - round-robin AW/W/B arbiter merging burst-write channels onto one AXI write port
module axis_write_arb #(
    parameter int CHANNELS        = 4,
    parameter int AXI_ID_WIDTH    = 8,
    parameter int AXI_LEN_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int ORDER_AWIDTH    = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CONFIG_ADDR     = 25,
    parameter int CONFIG_AWIDTH   = 5,
    parameter int CONFIG_DWIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CONFIG_AWIDTH-1:0]             cfg_addr,
    input  logic [CONFIG_DWIDTH-1:0]             cfg_data,
    input  logic                                 cfg_valid,
    input  logic [CHANNELS*AXI_ADDR_WIDTH-1:0]   ch_awaddr,
    input  logic [CHANNELS*AXI_LEN_WIDTH-1:0]    ch_awlen,
    input  logic [CHANNELS-1:0]                  ch_awvalid,
    output logic [CHANNELS-1:0]                  ch_awready,
    input  logic [CHANNELS*AXI_DATA_WIDTH-1:0]   ch_wdata,
    input  logic [CHANNELS-1:0]                  ch_wlast,
    input  logic [CHANNELS-1:0]                  ch_wvalid,
    output logic [CHANNELS-1:0]                  ch_wready,
    output logic [CHANNELS-1:0]                  ch_bdone,
    output logic [CHANNELS-1:0]                  ch_berr,
    input  logic                                 axi_awready,
    output logic [AXI_ID_WIDTH-1:0]              axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]            axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]             axi_awlen,
    output logic                                 axi_awvalid,
    input  logic                                 axi_wready,
    output logic [AXI_ID_WIDTH-1:0]              axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]            axi_wdata,
    output logic                                 axi_wlast,
    output logic                                 axi_wvalid,
    input  logic [AXI_ID_WIDTH-1:0]              axi_bid,
    input  logic [1:0]                           axi_bresp,
    input  logic                                 axi_bvalid,
    output logic                                 axi_bready
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 1 << ORDER_AWIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CHANNELS-1:0]   enable;
    logic [CH_W-1:0]       rr;
    logic [CNT_W-1:0]      outstanding [CHANNELS];
    logic [CH_W-1:0]       order_mem [DEPTH];
    logic [ORDER_AWIDTH:0] wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, pop, slot_free, grant;
    logic [CH_W-1:0]       head, winner;
    logic [CHANNELS-1:0]   eligible;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ORDER_AWIDTH] != rd_ptr[ORDER_AWIDTH]) &&
                        (wr_ptr[ORDER_AWIDTH-1:0] == rd_ptr[ORDER_AWIDTH-1:0]);
    assign head       = order_mem[rd_ptr[ORDER_AWIDTH-1:0]];
    assign axi_bready = 1'b1;

    // W beats follow the grant order; only the head channel sees wready
    assign axi_wvalid = !fifo_empty && ch_wvalid[head];
    assign axi_wlast  = ch_wlast[head];
    assign axi_wdata  = ch_wdata[int'(head)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign axi_wid    = fifo_empty ? '0 : AXI_ID_WIDTH'(head);
    assign pop        = axi_wvalid && axi_wready && axi_wlast;
    assign slot_free  = (!axi_awvalid || axi_awready) && (!fifo_full || pop);

    always_comb begin
        ch_wready = '0;
        if (!fifo_empty) ch_wready[head] = axi_wready;
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            eligible[i] = ch_awvalid[i] && enable[i] &&
                          (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
    end

    // Scan downward so the eligible channel closest to rr is the last write
    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
        grant = found && slot_free && !rst;
        ch_awready = '0;
        if (grant) ch_awready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (grant) order_mem[wr_ptr[ORDER_AWIDTH-1:0]] <= winner;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= '1;
            rr          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awid    <= '0;
            ch_bdone    <= '0;
            ch_berr     <= '0;
            for (int i = 0; i < CHANNELS; i++) outstanding[i] <= '0;
        end else begin
            if (grant) begin
                axi_awvalid <= 1'b1;
                axi_awaddr  <= ch_awaddr[int'(winner)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                axi_awlen   <= ch_awlen[int'(winner)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
                axi_awid    <= AXI_ID_WIDTH'(winner);
                wr_ptr      <= wr_ptr + 1'b1;
                rr          <= (winner == CH_W'(CHANNELS - 1)) ? '0 : winner + 1'b1;
            end else if (axi_awready) begin
                axi_awvalid <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if ((grant && winner == CH_W'(i)) && !(axi_bvalid && int'(axi_bid) == i))
                    outstanding[i] <= outstanding[i] + 1'b1;
                else if (!(grant && winner == CH_W'(i)) && (axi_bvalid && int'(axi_bid) == i))
                    outstanding[i] <= outstanding[i] - 1'b1;
                ch_bdone[i] <= axi_bvalid && (int'(axi_bid) == i);
                ch_berr[i]  <= axi_bvalid && (int'(axi_bid) == i) && (axi_bresp != 2'b00);
            end
            if (cfg_valid && cfg_addr == CONFIG_AWIDTH'(CONFIG_ADDR))
                enable <= cfg_data[CHANNELS-1:0];
        end
    end
endmodule

// File: tb/tb_axis_write_arb.sv
// tb/tb_axis_write_arb.sv - directed self-checking bench for axis_write_arb
module tb_axis_write_arb;
    localparam int CH = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      cfg_addr;
    logic [31:0]     cfg_data;
    logic            cfg_valid;
    logic [CH*AW-1:0] ch_awaddr;
    logic [CH*LW-1:0] ch_awlen;
    logic [CH-1:0]   ch_awvalid, ch_awready;
    logic [CH*DW-1:0] ch_wdata;
    logic [CH-1:0]   ch_wlast, ch_wvalid, ch_wready, ch_bdone, ch_berr;
    logic            axi_awready, axi_awvalid;
    logic [7:0]      axi_awid, axi_awlen, axi_wid, axi_bid;
    logic [31:0]     axi_awaddr;
    logic            axi_wready, axi_wlast, axi_wvalid;
    logic [DW-1:0]   axi_wdata;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid, axi_bready;

    int total = 0;
    int bad   = 0;

    axis_write_arb dut (
        .clk(clk), .rst(rst),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .ch_awaddr(ch_awaddr), .ch_awlen(ch_awlen), .ch_awvalid(ch_awvalid), .ch_awready(ch_awready),
        .ch_wdata(ch_wdata), .ch_wlast(ch_wlast), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .ch_bdone(ch_bdone), .ch_berr(ch_berr),
        .axi_awready(axi_awready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_wready(axi_wready), .axi_wid(axi_wid), .axi_wdata(axi_wdata),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
        ch_awaddr = '0; ch_awlen = '0; ch_awvalid = '0;
        ch_wdata = '0; ch_wlast = '0; ch_wvalid = '0;
        axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] expg;
    logic [3:0] seq5 [4];

    initial begin
        do_reset();
        settle();
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_awid", axi_awid, 0);
        chk("rst_awlen", axi_awlen, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_wid", axi_wid, 0);
        chk("rst_ch_awready", ch_awready, 0);
        chk("rst_ch_wready", ch_wready, 0);
        chk("rst_bdone", ch_bdone, 0);
        chk("rst_berr", ch_berr, 0);
        chk("rst_bready", axi_bready, 1);

        // single burst on channel 0
        axi_awready = 1'b1; axi_wready = 1'b1;
        ch_awaddr[0 +: AW] = 32'h1000; ch_awlen[0 +: LW] = 8'd3; ch_awvalid[0] = 1'b1;
        settle();
        chk("t1_grant", ch_awready, 4'b0001);
        tick();
        ch_awvalid[0] = 1'b0;
        settle();
        chk("t1_awvalid", axi_awvalid, 1);
        chk("t1_awaddr", axi_awaddr, 32'h1000);
        chk("t1_awid", axi_awid, 0);
        chk("t1_awlen", axi_awlen, 3);
        for (int b = 0; b < 4; b++) begin
            ch_wdata[0 +: DW] = 256'hA0 + 256'(b);
            ch_wvalid[0] = 1'b1;
            ch_wlast[0] = (b == 3);
            settle();
            chk("t1_wvalid", axi_wvalid, 1);
            chk("t1_wdata", axi_wdata, 256'hA0 + 256'(b));
            chk("t1_wlast", axi_wlast, (b == 3));
            chk("t1_ch_wready", ch_wready, 4'b0001);
            tick();
        end
        ch_wvalid = '0; ch_wlast = '0;
        settle();
        chk("t1_fifo_empty_wready", ch_wready, 0);
        chk("t1_awvalid_clear", axi_awvalid, 0);
        axi_bvalid = 1'b1; axi_bid = 8'd0; axi_bresp = 2'd0;
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("t1_bdone", ch_bdone, 4'b0001);
        chk("t1_berr", ch_berr, 0);
        tick();
        chk("t1_bdone_pulse", ch_bdone, 0);

        // round-robin across all channels until the order FIFO fills
        do_reset();
        axi_awready = 1'b1;
        ch_awvalid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            expg = 4'(1 << (k % 4));
            chk("t2_rr_grant", ch_awready, expg);
            if (k > 0) chk("t2_rr_awid", axi_awid, (k - 1) % 4);
            tick();
        end
        settle();
        chk("t2_full_stall", ch_awready, 0);
        chk("t2_last_awid", axi_awid, 3);
        axi_wready = 1'b1; ch_wvalid[0] = 1'b1; ch_wlast[0] = 1'b1;
        settle();
        chk("t2_pop_wid", axi_wid, 0);
        chk("t2_pop_regrant", ch_awready, 4'b0001);
        tick();

        // outstanding limit on channel 2
        do_reset();
        axi_awready = 1'b1;
        ch_awvalid[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_grant", ch_awready, 4'b0100);
            tick();
        end
        settle();
        chk("t3_limit_hold", ch_awready, 0);
        axi_bvalid = 1'b1; axi_bid = 8'd5;
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("t3_bad_bid_bdone", ch_bdone, 0);
        chk("t3_bad_bid_hold", ch_awready, 0);
        axi_bvalid = 1'b1; axi_bid = 8'd2;
        settle();
        chk("t3_same_cycle_hold", ch_awready, 0);
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("t3_bdone", ch_bdone, 4'b0100);
        chk("t3_regrant", ch_awready, 4'b0100);

        // W ordering: channel 1 then channel 3
        do_reset();
        axi_awready = 1'b1;
        ch_awvalid[1] = 1'b1;
        tick();
        ch_awvalid[1] = 1'b0; ch_awvalid[3] = 1'b1;
        settle();
        chk("t4_grant3", ch_awready, 4'b1000);
        tick();
        ch_awvalid = '0;
        axi_wready = 1'b1;
        ch_wdata[1*DW +: DW] = 256'h11; ch_wdata[3*DW +: DW] = 256'h33;
        ch_wvalid[1] = 1'b1; ch_wvalid[3] = 1'b1; ch_wlast[3] = 1'b1;
        settle();
        chk("t4_hold3", ch_wready, 4'b0010);
        chk("t4_wid1", axi_wid, 1);
        tick();
        ch_wlast[1] = 1'b1;
        settle();
        chk("t4_last1", axi_wlast, 1);
        tick();
        ch_wvalid[1] = 1'b0;
        settle();
        chk("t4_wid3", axi_wid, 3);
        chk("t4_wready3", ch_wready, 4'b1000);
        chk("t4_wdata3", axi_wdata, 256'h33);
        tick();

        // channel enable mask and error response
        do_reset();
        axi_awready = 1'b1;
        cfg_valid = 1'b1; cfg_addr = 5'd24; cfg_data = 32'h0;
        tick();
        cfg_valid = 1'b0;
        ch_awvalid[1] = 1'b1;
        settle();
        chk("t5_wrong_addr_ignored", ch_awready, 4'b0010);
        tick();
        ch_awvalid = '0;
        cfg_valid = 1'b1; cfg_addr = 5'd25; cfg_data = 32'hD;
        tick();
        cfg_valid = 1'b0;
        ch_awvalid = 4'b1111;
        seq5[0] = 4'b0100; seq5[1] = 4'b1000; seq5[2] = 4'b0001; seq5[3] = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t5_masked_grant", ch_awready, seq5[k]);
            tick();
        end
        ch_awvalid = '0;
        axi_wready = 1'b1; ch_wvalid[1] = 1'b1; ch_wlast[1] = 1'b1;
        settle();
        chk("t5_inflight1_wready", ch_wready, 4'b0010);
        chk("t5_inflight1_wid", axi_wid, 1);
        tick();
        ch_wvalid = '0; ch_wlast = '0;
        axi_bvalid = 1'b1; axi_bid = 8'd0; axi_bresp = 2'd2;
        tick();
        axi_bvalid = 1'b0;
        settle();
        chk("t5_berr", ch_berr, 4'b0001);
        chk("t5_bdone", ch_bdone, 4'b0001);

        // reset in the middle of a burst
        do_reset();
        ch_awaddr[0 +: AW] = 32'h2000; ch_awlen[0 +: LW] = 8'd1; ch_awvalid[0] = 1'b1;
        tick();
        axi_wready = 1'b1; ch_wvalid[0] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        settle();
        chk("t6_awvalid", axi_awvalid, 0);
        chk("t6_awaddr", axi_awaddr, 0);
        chk("t6_awlen", axi_awlen, 0);
        chk("t6_wvalid", axi_wvalid, 0);
        chk("t6_ch_wready", ch_wready, 0);
        chk("t6_ch_awready", ch_awready, 0);
        chk("t6_bready", axi_bready, 1);
        rst = 1'b0;
        ch_wvalid = '0;
        axi_awready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t6_counter_cleared", ch_awready, 4'b0001);
            tick();
        end
        settle();
        chk("t6_awid_after", axi_awid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_write_arb.md
# axis_write_arb

Round-robin write arbiter that merges CHANNELS independent burst-write clients (each an axis_write-style AW/W source) onto one AXI write master port. It tags every burst with the channel index as AXI ID and keeps an in-order grant queue to steer W beats. It also tracks outstanding bursts per channel and returns per-channel B completions, so several streams can share one HP port. It sits between the per-channel write engines and the AXI interconnect, beside the existing stream top level.

## Interface
- CHANNELS, 4, number of client channels (2..2^AXI_ID_WIDTH)
- AXI_ID_WIDTH, 8, AXI ID width; ID = channel index, zero-extended
- AXI_LEN_WIDTH, 8, burst length field width
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 256, data width
- ORDER_AWIDTH, 3, log2 depth of grant-order FIFO (8 entries)
- MAX_OUTSTANDING, 4, max un-responded bursts per channel
- CONFIG_ADDR, 25, cfg register address of channel-enable mask
- CONFIG_AWIDTH, 5 / CONFIG_DWIDTH, 32, cfg bus widths

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_addr / cfg_data / cfg_valid  in  CONFIG_AWIDTH / CONFIG_DWIDTH / 1  config write bus
- ch_awaddr  in  CHANNELS*AXI_ADDR_WIDTH  per-channel burst address (channel i at slice i)
- ch_awlen  in  CHANNELS*AXI_LEN_WIDTH  per-channel burst length-1
- ch_awvalid / ch_awready  in / out  CHANNELS  per-channel AW handshake
- ch_wdata  in  CHANNELS*AXI_DATA_WIDTH  per-channel write data
- ch_wlast / ch_wvalid  in  CHANNELS  per-channel last / valid
- ch_wready  out  CHANNELS  per-channel W ready
- ch_bdone / ch_berr  out  CHANNELS  completion pulse / error flag (bresp != 0)
- axi_awready  in  1; axi_awid, axi_awaddr, axi_awlen, axi_awvalid  out  ID/ADDR/LEN/1
- axi_wready  in  1; axi_wid, axi_wdata, axi_wlast, axi_wvalid  out  ID/DATA/1/1
- axi_bid, axi_bresp, axi_bvalid  in  ID/2/1; axi_bready  out  1

## Operation
- Eligible channel: ch_awvalid=1, enable bit=1, outstanding count < MAX_OUTSTANDING.
- AW slot free when axi_awvalid=0 or axi_awready=1 this cycle, and order FIFO not full (accounting for same-cycle pop).
- Slot free and any eligible: pick first eligible at or after rr pointer (wrapping). Register addr/len, axi_awid=winner, axi_awvalid<=1. Pulse ch_awready[winner] that cycle (combinational grant). Push winner into order FIFO. rr pointer <= winner+1 mod CHANNELS.
- axi_awvalid held with stable fields until axi_awready; then cleared unless a new grant loads.
- W steering: FIFO non-empty, head=h: axi_wvalid=ch_wvalid[h], axi_wdata/axi_wlast from channel h, axi_wid=h, ch_wready[h]=axi_wready; all other ch_wready=0. FIFO empty: axi_wvalid=0, all ch_wready=0. Pop on handshake with wlast=1. W beats may precede the AXI AW handshake (AXI-legal).
- Outstanding counter per channel: +1 on grant, -1 on B handshake with bid=i. Same-cycle grant and B on one channel: unchanged.
- axi_bready tied 1. B with bid=i: ch_bdone[i]=1 and ch_berr[i]=(bresp!=0) for one cycle, registered. bid >= CHANNELS: dropped, no counter change.
- cfg_valid and cfg_addr==CONFIG_ADDR: enable <= cfg_data[CHANNELS-1:0]. Clearing a bit blocks new grants only; queued bursts finish.
- Reset mid-operation clears all state; in-flight AXI transactions are abandoned, and reset is system-wide.

## Timing
- Reset values: axi_awvalid/awaddr/awlen/awid=0, axi_wvalid=0, axi_wid=0, all ch_awready/ch_wready/ch_bdone/ch_berr=0, axi_bready=1, enable=all ones, rr=0, counters=0, FIFO empty.
- Grant latency: ch_awvalid high with slot free -> ch_awready same cycle, axi_awvalid next cycle.
- With axi_awready held 1: one grant per cycle sustained.
- W path combinational, zero latency. Back-to-back bursts of different channels need no idle beat.
- B -> ch_bdone one cycle later; counter updates on the B edge.

## Test plan
- Single channel 0, addr 0x1000, len 3, awready=wready=1 -> axi_awid=0, awaddr 0x1000 one cycle after grant; 4 W beats, wlast on 4th; bid=0 -> ch_bdone[0] next cycle.
- All 4 channels awvalid constantly, awready=1 -> grant order 0,1,2,3,0,... one per cycle. FIFO fills at 8 and grants stall until wlast pops.
- Channel 2 issues 4 bursts with no B -> 5th request held; one B with bid=2 -> grant next cycle.
- Bursts granted 1 then 3 -> W beats of channel 3 held (ch_wready[3]=0) until channel 1 wlast handshake, then axi_wid=3.
- cfg write CONFIG_ADDR data 0b1101 -> channel 1 never granted, in-flight burst of 1 completes; bresp=2 on bid=0 -> ch_berr[0] pulses.
- rst asserted mid-burst -> next cycle all outputs at reset values, FIFO empty, counters 0.
